// File: rtl/arb_pkg.sv
// Shared types and ring helpers for the round-robin arbiter.
// Ring helpers operate on a fixed-width vector; callers cast to N bits.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_MAXN = 32;

  typedef logic [ARB_MAXN-1:0] ring_vec_t;

  // Rotate the low n bits of v left by one, MSB wrapping to bit 0.
  function automatic ring_vec_t rotl1(
    input ring_vec_t   v,
    input int unsigned n
  );
    ring_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < ARB_MAXN; i++) begin
      if (i < n) begin
        if (i == n - 1) r[0] = v[i];
        else            r[(i + 1) % ARB_MAXN] = v[i];
      end
    end
    return r;
  endfunction

  // Index of the set bit of a one-hot vector (0 for all-zero).
  function automatic int unsigned onehot2idx(
    input ring_vec_t v
  );
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAXN; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_token_ptr.sv
// One-hot priority token ring for the round-robin arbiter.
// On load the token moves to the slot just after the released grant.
module ring_token_ptr
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] gnt_onehot,
  output logic [N-1:0] token
);

  logic [N-1:0] token_q;

  // Token register: bit0 after reset, advances past each served requester.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      token_q <= N'(1);
    end else if (load) begin
      token_q <= N'(rotl1(ARB_MAXN'(gnt_onehot), N));
    end
  end

  assign token = token_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Ring-token round-robin arbiter with per-grant hold timeout.
// Define ARB_LOCK_EN to add a lock input that suppresses the timeout.
module ring_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic                 lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_t    state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] gnt_id_q;
  logic [HW-1:0] hold_q;
  logic          timeout_q;

  logic [N-1:0]  token;
  logic          lock_w;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic          g_req;
  logic          at_max;
  logic          rel;
  logic          rel_to;

`ifdef ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  ring_token_ptr #(
    .N (N)
  ) u_token (
    .Clk        (Clk),
    .reset      (reset),
    .load       (rel),
    .gnt_onehot (gnt_q),
    .token      (token)
  );

  // First requester in ring order starting at the token position.
  always_comb begin
    int unsigned   tok_idx;
    int unsigned   j;
    logic [IW-1:0] jx;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    j          = 0;
    jx         = '0;
    tok_idx    = onehot2idx(ARB_MAXN'(token));
    for (int unsigned k = 0; k < N; k++) begin
      j  = (tok_idx + k) % N;
      jx = IW'(j);
      if (!pick_found && req[jx]) begin
        pick_found = 1'b1;
        pick_idx   = jx;
      end
    end
    pick_oh[pick_idx] = pick_found;
  end

  // Release decision for the grant in progress.
  always_comb begin
    g_req  = req[gnt_id_q];
    at_max = (hold_q == HW'(HOLD_MAX));
    rel    = (state_q == ARB_GRANT) &&
             (!g_req || (at_max && !lock_w));
    rel_to = (state_q == ARB_GRANT) &&
             g_req && at_max && !lock_w;
  end

  // Arbiter FSM with registered grant, id, hold count and timeout.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          timeout_q <= 1'b0;
          if (en && pick_found) begin
            gnt_q    <= pick_oh;
            gnt_id_q <= pick_idx;
            hold_q   <= HW'(1);
            state_q  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (rel) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            hold_q    <= '0;
            timeout_q <= rel_to;
            state_q   <= ARB_GAP;
          end else begin
            timeout_q <= 1'b0;
            if (!at_max) hold_q <= hold_q + HW'(1);
          end
        end
        ARB_GAP: begin
          timeout_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
        default: begin
          gnt_q     <= '0;
          gnt_id_q  <= '0;
          hold_q    <= '0;
          timeout_q <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != ARB_IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed literal checks plus random
// stimulus compared every cycle against a behavioural model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic         Clk;
  logic         reset;
  logic         en;
  logic [N-1:0] req;
  logic         lock;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int checks = 0;
  int passes = 0;

  ring_rr_arbiter #(
    .N        (N),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .Clk     (Clk),
    .reset   (reset),
    .en      (en),
    .req     (req),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, got, exp, $time);
  endtask

  // Behavioural model: owner index, cycles held, dead-cycle flag, pointer.
  int m_owner;
  int m_held;
  int m_gap;
  int m_ptr;
  int m_to;

  task automatic m_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_held  = 0;
    m_gap   = 1;
  endtask

  task automatic m_step();
    logic lk;
    logic rq;
`ifdef ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    m_to = 0;
    if (m_owner >= 0) begin
      rq = ((req >> m_owner) & 4'b1) != 0;
      if (!rq) m_release();
      else if (m_held == HOLD_MAX && !lk) begin
        m_release();
        m_to = 1;
      end else if (m_held < HOLD_MAX) m_held++;
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (en && req != 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_owner < 0 && ((req >> j) & 4'b1) != 0) m_owner = j;
      end
      m_held = 1;
    end
  endtask

  // Compare process: advance the model on each edge, check 1 time unit later.
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_owner = -1;
      m_held  = 0;
      m_gap   = 0;
      m_ptr   = 0;
      m_to    = 0;
    end else begin
      m_step();
    end
    #1;
    chk("model_gnt", 32'(gnt),
        (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("model_gnt_id", 32'(gnt_id),
        (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("model_busy", 32'(busy),
        32'((m_owner >= 0) || (m_gap != 0)));
    chk("model_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    seq[4] = 4'b0001;

    reset = 1'b1;
    en    = 1'b0;
    req   = '0;
    lock  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);

    // single requester runs to timeout
    en  = 1'b1;
    req = 4'b0001;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (7) begin
      tick();
      chk("t1_hold", 32'(gnt), 32'h1);
    end
    tick();
    chk("t1_rel", 32'(gnt), 32'd0);
    chk("t1_to", 32'(timeout), 32'd1);
    req = '0;
    repeat (3) tick();

    // all requesting: ring order with 8-cycle grants
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t2_gnt", 32'(gnt), 32'(seq[s]));
      repeat (7) tick();
      chk("t2_last", 32'(gnt), 32'(seq[s]));
      tick();
      chk("t2_to", 32'(timeout), 32'd1);
      chk("t2_gap", 32'(gnt), 32'd0);
      tick();
      chk("t2_idle", 32'(gnt), 32'd0);
      chk("t2_nto", 32'(timeout), 32'd0);
    end

    // early release, then the token points past requester 2
    do_reset();
    req = '0;
    tick();
    req = 4'b0100;
    repeat (3) begin
      tick();
      chk("t3_gnt", 32'(gnt), 32'h4);
      chk("t3_id", 32'(gnt_id), 32'd2);
    end
    req = '0;
    tick();
    chk("t3_rel", 32'(gnt), 32'd0);
    chk("t3_nto", 32'(timeout), 32'd0);
    tick();
    req = 4'b1111;
    tick();
    chk("t3_next", 32'(gnt), 32'h8);
    chk("t3_nid", 32'(gnt_id), 32'd3);
    req = '0;
    repeat (4) tick();

    // enable gates new grants only
    do_reset();
    en  = 1'b0;
    req = 4'b1111;
    repeat (3) begin
      tick();
      chk("t4_off", 32'(gnt), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
    end
    en = 1'b1;
    tick();
    chk("t4_on", 32'(gnt), 32'h1);
    en = 1'b0;
    repeat (7) tick();
    chk("t4_hold", 32'(gnt), 32'h1);
    tick();
    chk("t4_to", 32'(timeout), 32'd1);
    repeat (4) begin
      tick();
      chk("t4_nonew", 32'(gnt), 32'd0);
    end

    // asynchronous reset mid-grant
    do_reset();
    en  = 1'b1;
    req = 4'b0100;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async", 32'(gnt), 32'd0);
    chk("t5_abusy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    req   = 4'b1001;
    tick();
    chk("t5_tok", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) tick();

`ifdef ARB_LOCK_EN
    do_reset();
    req  = 4'b0010;
    lock = 1'b1;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h2);
    repeat (20) begin
      tick();
      chk("t6_lock", 32'(gnt), 32'h2);
      chk("t6_nto", 32'(timeout), 32'd0);
    end
    lock = 1'b0;
    tick();
    chk("t6_rel", 32'(gnt), 32'd0);
    chk("t6_to", 32'(timeout), 32'd1);
    req = '0;
    repeat (3) tick();
`endif

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      lock = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
